tl_vc_credit_scheduler: RTL and testbench
=========================================

// Module: tl_vc_credit_scheduler
// PURPOSE
//  Credit-gated weighted round-robin scheduler for the TL RX virtual-channel FIFOs.
//  Picks one VC per transfer, honouring a programmable per-VC weight and blocking any
//  VC whose flow-control credit count is zero. Sits between the VC FIFOs and the
//  TL RX decode stage, with one registered output stage.
// PARAMETERS
//  N_VC        2   number of virtual channels / requesters (2..8)
//  DATA_SIZE   32  payload width per transfer
//  WEIGHT_W    4   width of each per-VC weight field
//  CREDIT_W    8   width of each per-VC credit counter
//  CREDIT_INIT 16  credit counter value after reset (< 2**CREDIT_W)
// PORTS
//  clk             in   1                    clock
//  rst_n           in   1                    async active-low reset
//  cfg_weight_i    in   N_VC*WEIGHT_W        per-VC weight, VC k at [k*WEIGHT_W +: WEIGHT_W]
//  credit_ret_i    in   N_VC                 one-cycle pulse: return 1 credit to VC k
//  src_valid_i     in   N_VC                 VC k FIFO not empty
//  src_ready_o     out  N_VC                 VC k transfer accepted (one-hot or zero)
//  src_data_i      in   N_VC*DATA_SIZE       VC k payload at [k*DATA_SIZE +: DATA_SIZE]
//  dst_valid_o     out  1                    output register holds a transfer
//  dst_ready_i     in   1                    downstream accepts
//  dst_data_o      out  DATA_SIZE            granted payload
//  dst_vc_o        out  $clog2(N_VC)         VC index of dst_data_o
//  credit_o        out  N_VC*CREDIT_W        current credit counters
// BEHAVIOUR
//  - Reset (async): dst_valid_o=0, dst_data_o=0, dst_vc_o=0, credit[k]=CREDIT_INIT,
//    cur_vc=0, wcnt=0, state=S_IDLE. src_ready_o is comb and is 0 while rst_n=0.
//  - eligible[k] = src_valid_i[k] && credit[k]!=0. Effective weight = max(cfg_weight,1).
//  - Output slot free: slot_free = !dst_valid_o || dst_ready_i. No grant unless slot_free.
//  - Grant rule (comb, same cycle): if eligible[cur_vc] && wcnt<weight[cur_vc] grant cur_vc;
//    else grant first eligible VC scanning cur_vc+1, cur_vc+2 ... mod N_VC; else none.
//  - On grant g: src_ready_o[g]=1; next cycle dst_valid_o=1, dst_data_o=src_data[g],
//    dst_vc_o=g. Latency src accept -> dst_valid = 1 clock. Full throughput 1/clk.
//  - Weight counter: grant to cur_vc -> wcnt+1; grant to other VC -> cur_vc=g, wcnt=1.
//    wcnt reaching weight does not move cur_vc by itself; rotation happens on next grant.
//  - Output hold: dst_valid_o && !dst_ready_i -> data/vc stable, no src_ready_o asserted.
//  - dst accept without new grant -> dst_valid_o=0 next cycle.
//  - Credits: grant to k -> credit[k]-1; credit_ret_i[k] -> +1; both same cycle -> unchanged.
//    Return at all-ones without grant is dropped (saturate). Credit 0 never decremented.
//  - cfg_weight_i sampled live; change mid-phase applies to the next compare.
//  - FSM: S_IDLE (dst_valid_o=0) -> S_SEND on grant; S_SEND -> S_STALL when !dst_ready_i;
//    S_STALL -> S_SEND on dst_ready_i with grant, -> S_IDLE on dst_ready_i w/o grant;
//    S_SEND -> S_IDLE on dst_ready_i w/o grant.
//  - rst_n low mid-transfer: in-flight dst data discarded, credits reload CREDIT_INIT.
// CONFIGURATION
//  TL_VC_SCHED_STATS_EN defined: adds output stat_grant_o (N_VC*16), per-VC grant count,
//  wraps at 16'hFFFF->0, cleared by reset, incremented on each src_ready_o[k].
//  Undefined: port and counters absent; all other behaviour identical.
// TESTING
//  - N_VC=2, weights {VC1=3,VC0=1}, both valid, dst_ready=1 -> grant order 0,1,1,1,0,1,1,1.
//  - VC0 only valid, weight 1 -> back-to-back grants to VC0 every cycle, dst_vc_o=0.
//  - CREDIT_INIT=2, VC0 valid, no returns -> 2 grants then src_ready_o[0]=0; pulse
//    credit_ret_i[0] -> exactly 1 more grant; credit_o[0] ends at 0.
//  - dst_ready_i=0 for 5 cycles with dst_valid_o=1 -> dst_data_o stable, src_ready_o=0.
//  - Grant and credit_ret_i same VC same cycle at credit 5 -> credit stays 5.
//  - Assert rst_n=0 mid-burst -> dst_valid_o=0 immediately, credits=CREDIT_INIT, cur_vc=0.

Source files
------------

// File: rtl/tl_vc_credit_scheduler_if.sv
// Source/destination handshake bundle for the VC credit scheduler.
// The slave modport is the scheduler's view; master is the surrounding FIFOs and decode stage.
interface tl_vc_credit_scheduler_if #(
   parameter int N_VC      = 2,
   parameter int DATA_SIZE = 32,
   parameter int VC_W      = (N_VC > 1) ? $clog2(N_VC) : 1
);
   logic [N_VC-1:0]           src_valid_i;
   logic [N_VC-1:0]           src_ready_o;
   logic [N_VC*DATA_SIZE-1:0] src_data_i;
   logic                      dst_valid_o;
   logic                      dst_ready_i;
   logic [DATA_SIZE-1:0]      dst_data_o;
   logic [VC_W-1:0]           dst_vc_o;

   modport slave (
      input  src_valid_i, src_data_i, dst_ready_i,
      output src_ready_o, dst_valid_o, dst_data_o, dst_vc_o
   );

   modport master (
      output src_valid_i, src_data_i, dst_ready_i,
      input  src_ready_o, dst_valid_o, dst_data_o, dst_vc_o
   );
endinterface

// File: rtl/tl_vc_credit_scheduler.sv
// Credit-gated weighted round-robin VC scheduler; TL_VC_SCHED_STATS_EN adds per-VC grant counters.
// Latency: source accept to dst_valid_o is 1 clock, sustaining one transfer per clock.
// Backpressure: while dst_valid_o && !dst_ready_i the output holds and no source is accepted.
module tl_vc_credit_scheduler #(
   parameter int N_VC        = 2,
   parameter int DATA_SIZE   = 32,
   parameter int WEIGHT_W    = 4,
   parameter int CREDIT_W    = 8,
   parameter int CREDIT_INIT = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_VC*WEIGHT_W-1:0]   cfg_weight_i,
   input  logic [N_VC-1:0]            credit_ret_i,
   tl_vc_credit_scheduler_if.slave    bus,
   output logic [N_VC*CREDIT_W-1:0]   credit_o
`ifdef TL_VC_SCHED_STATS_EN
   ,
   output logic [N_VC*16-1:0]         stat_grant_o
`endif
);
   localparam int VC_W = (N_VC > 1) ? $clog2(N_VC) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_STALL} state_t;

   state_t               state_q, state_d;
   logic [CREDIT_W-1:0]  credit_q [N_VC];
   logic [CREDIT_W-1:0]  credit_d [N_VC];
   logic [VC_W-1:0]      cur_vc_q, cur_vc_d;
   logic [WEIGHT_W-1:0]  wcnt_q, wcnt_d;
   logic [DATA_SIZE-1:0] dst_data_q, dst_data_d;
   logic [VC_W-1:0]      dst_vc_q, dst_vc_d;

   logic [N_VC-1:0]      elig;
   logic [WEIGHT_W-1:0]  eff_w [N_VC];
   logic                 slot_free;
   logic                 grant_vld;
   logic                 grant_keep;
   logic [VC_W-1:0]      grant_idx;
   logic [VC_W-1:0]      cand;
   logic [N_VC-1:0]      src_rdy;

   always_comb begin
      for (int k = 0; k < N_VC; k++) begin
         eff_w[k] = cfg_weight_i[k*WEIGHT_W +: WEIGHT_W];
         if (eff_w[k] == '0) eff_w[k] = WEIGHT_W'(1);
         elig[k] = bus.src_valid_i[k] && (credit_q[k] != '0);
      end
   end

   assign slot_free = (state_q == S_IDLE) || bus.dst_ready_i;

   // The scan includes cur_vc itself as its last candidate, so a lone VC keeps getting grants.
   always_comb begin
      grant_vld  = 1'b0;
      grant_keep = 1'b0;
      grant_idx  = '0;
      cand       = '0;
      if (rst_n && slot_free) begin
         if (elig[cur_vc_q] && (wcnt_q < eff_w[cur_vc_q])) begin
            grant_vld  = 1'b1;
            grant_keep = 1'b1;
            grant_idx  = cur_vc_q;
         end else begin
            for (int i = 1; i <= N_VC; i++) begin
               cand = VC_W'((int'(cur_vc_q) + i) % N_VC);
               if (!grant_vld && elig[cand]) begin
                  grant_vld = 1'b1;
                  grant_idx = cand;
               end
            end
         end
      end
   end

   always_comb begin
      src_rdy = '0;
      if (grant_vld) src_rdy[grant_idx] = 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      cur_vc_d   = cur_vc_q;
      wcnt_d     = wcnt_q;
      dst_data_d = dst_data_q;
      dst_vc_d   = dst_vc_q;
      for (int k = 0; k < N_VC; k++) credit_d[k] = credit_q[k];

      case (state_q)
         S_IDLE: if (grant_vld) state_d = S_SEND;
         S_SEND, S_STALL: begin
            if (!bus.dst_ready_i)  state_d = S_STALL;
            else if (grant_vld)    state_d = S_SEND;
            else                   state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (grant_vld) begin
         dst_data_d = bus.src_data_i[int'(grant_idx)*DATA_SIZE +: DATA_SIZE];
         dst_vc_d   = grant_idx;
         if (grant_keep) begin
            wcnt_d = wcnt_q + WEIGHT_W'(1);
         end else begin
            cur_vc_d = grant_idx;
            wcnt_d   = WEIGHT_W'(1);
         end
      end

      // Simultaneous grant and return cancel; a return into a full counter is dropped.
      for (int k = 0; k < N_VC; k++) begin
         if (src_rdy[k] && !credit_ret_i[k])
            credit_d[k] = credit_q[k] - CREDIT_W'(1);
         else if (credit_ret_i[k] && !src_rdy[k] && (credit_q[k] != '1))
            credit_d[k] = credit_q[k] + CREDIT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cur_vc_q   <= '0;
         wcnt_q     <= '0;
         dst_data_q <= '0;
         dst_vc_q   <= '0;
         for (int k = 0; k < N_VC; k++) credit_q[k] <= CREDIT_W'(CREDIT_INIT);
      end else begin
         state_q    <= state_d;
         cur_vc_q   <= cur_vc_d;
         wcnt_q     <= wcnt_d;
         dst_data_q <= dst_data_d;
         dst_vc_q   <= dst_vc_d;
         for (int k = 0; k < N_VC; k++) credit_q[k] <= credit_d[k];
      end
   end

   assign bus.src_ready_o = src_rdy;
   assign bus.dst_valid_o = (state_q != S_IDLE);
   assign bus.dst_data_o  = dst_data_q;
   assign bus.dst_vc_o    = dst_vc_q;

   always_comb begin
      credit_o = '0;
      for (int k = 0; k < N_VC; k++) credit_o[k*CREDIT_W +: CREDIT_W] = credit_q[k];
   end

`ifdef TL_VC_SCHED_STATS_EN
   logic [15:0] stat_q [N_VC];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N_VC; k++) stat_q[k] <= '0;
      end else begin
         for (int k = 0; k < N_VC; k++)
            if (src_rdy[k]) stat_q[k] <= stat_q[k] + 16'd1;
      end
   end

   always_comb begin
      stat_grant_o = '0;
      for (int k = 0; k < N_VC; k++) stat_grant_o[k*16 +: 16] = stat_q[k];
   end
`endif
endmodule

// File: tb/tb_tl_vc_credit_scheduler.sv
// Directed bench for tl_vc_credit_scheduler (N_VC=2, CREDIT_INIT=16).
module tb_tl_vc_credit_scheduler;
   localparam int N_VC = 2;
   localparam int DW   = 32;

   logic            clk;
   logic            rst_n;
   logic [7:0]      cfg_weight;
   logic [1:0]      credit_ret;
   logic [15:0]     credit;
`ifdef TL_VC_SCHED_STATS_EN
   logic [31:0]     stat_grant;
`endif

   int n_vec;
   int n_err;

   localparam logic [31:0] D0 = 32'hAAAA_0000;
   localparam logic [31:0] D1 = 32'hBBBB_1111;

   tl_vc_credit_scheduler_if #(.N_VC(N_VC), .DATA_SIZE(DW)) bus ();

   tl_vc_credit_scheduler #(
      .N_VC(N_VC), .DATA_SIZE(DW), .WEIGHT_W(4), .CREDIT_W(8), .CREDIT_INIT(16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_weight_i (cfg_weight),
      .credit_ret_i (credit_ret),
      .bus          (bus),
      .credit_o     (credit)
`ifdef TL_VC_SCHED_STATS_EN
      ,
      .stat_grant_o (stat_grant)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      cfg_weight      = 8'h31;
      credit_ret      = 2'b00;
      bus.src_valid_i = 2'b00;
      bus.src_data_i  = {D1, D0};
      bus.dst_ready_i = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_inputs();
      bus.src_valid_i = 2'b11;
      #1;
      n_vec++;
      if (bus.src_ready_o !== 2'b00) begin
         n_err++; $display("FAIL reset_src_ready got %b exp 00", bus.src_ready_o);
      end
      n_vec++;
      if (bus.dst_valid_o !== 1'b0 || bus.dst_data_o !== 32'h0 || bus.dst_vc_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_dst got v=%b d=%h vc=%b exp 0/0/0",
                  bus.dst_valid_o, bus.dst_data_o, bus.dst_vc_o);
      end
      n_vec++;
      if (credit !== {8'd16, 8'd16}) begin
         n_err++; $display("FAIL reset_credit got %h exp 1010", credit);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_wrr();
      int exp_order [8] = '{0, 1, 1, 1, 0, 1, 1, 1};
      logic [1:0]  oh;
      logic [31:0] ed;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         cfg_weight      = 8'h31;
         bus.src_valid_i = 2'b11;
         #1;
         oh = 2'b00;
         oh[exp_order[i]] = 1'b1;
         ed = (exp_order[i] == 0) ? D0 : D1;
         n_vec++;
         if (bus.src_ready_o !== oh) begin
            n_err++; $display("FAIL wrr_rdy[%0d] got %b exp %b", i, bus.src_ready_o, oh);
         end
         @(posedge clk); #1;
         n_vec++;
         if (bus.dst_valid_o !== 1'b1 || bus.dst_vc_o !== 1'(exp_order[i]) || bus.dst_data_o !== ed) begin
            n_err++;
            $display("FAIL wrr_dst[%0d] got v=%b vc=%0d d=%h exp v=1 vc=%0d d=%h",
                     i, bus.dst_valid_o, bus.dst_vc_o, bus.dst_data_o, exp_order[i], ed);
         end
      end
      n_vec++;
      if (credit !== {8'd10, 8'd14}) begin
         n_err++; $display("FAIL wrr_credit got %h exp 0a0e", credit);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         cfg_weight      = 8'h30;
         bus.src_valid_i = 2'b01;
         bus.src_data_i  = {D1, 32'(100 + i)};
         #1;
         n_vec++;
         if (bus.src_ready_o !== 2'b01) begin
            n_err++; $display("FAIL b2b_rdy[%0d] got %b exp 01", i, bus.src_ready_o);
         end
         @(posedge clk); #1;
         n_vec++;
         if (bus.dst_valid_o !== 1'b1 || bus.dst_vc_o !== 1'b0 || bus.dst_data_o !== 32'(100 + i)) begin
            n_err++;
            $display("FAIL b2b_dst[%0d] got v=%b vc=%0d d=%0d exp v=1 vc=0 d=%0d",
                     i, bus.dst_valid_o, bus.dst_vc_o, bus.dst_data_o, 100 + i);
         end
      end
      @(negedge clk);
      bus.src_valid_i = 2'b00;
      @(posedge clk); #1;
      n_vec++;
      if (bus.dst_valid_o !== 1'b0) begin
         n_err++; $display("FAIL b2b_drain got v=%b exp 0", bus.dst_valid_o);
      end
   endtask

   task automatic test_credit_exhaust();
      int grants;
      do_reset();
      grants = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         bus.src_valid_i = 2'b01;
         #1;
         if (bus.src_ready_o[0]) grants++;
      end
      n_vec++;
      if (grants != 16) begin
         n_err++; $display("FAIL exhaust_grants got %0d exp 16", grants);
      end
      n_vec++;
      if (credit[7:0] !== 8'd0 || bus.src_ready_o !== 2'b00) begin
         n_err++; $display("FAIL exhaust_zero got cr=%0d rdy=%b exp 0/00", credit[7:0], bus.src_ready_o);
      end
      @(posedge clk); #1;
      n_vec++;
      if (bus.dst_valid_o !== 1'b0) begin
         n_err++; $display("FAIL exhaust_idle got v=%b exp 0", bus.dst_valid_o);
      end
      grants = 0;
      @(negedge clk);
      credit_ret = 2'b01;
      #1;
      if (bus.src_ready_o[0]) grants++;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         credit_ret = 2'b00;
         #1;
         if (bus.src_ready_o[0]) grants++;
      end
      n_vec++;
      if (grants != 1 || credit[7:0] !== 8'd0) begin
         n_err++; $display("FAIL exhaust_return got grants=%0d cr=%0d exp 1/0", grants, credit[7:0]);
      end
   endtask

   task automatic test_credit_saturate();
      do_reset();
      for (int i = 0; i < 245; i++) begin
         @(negedge clk);
         credit_ret = 2'b10;
      end
      @(negedge clk);
      credit_ret = 2'b00;
      #1;
      n_vec++;
      if (credit !== {8'd255, 8'd16}) begin
         n_err++; $display("FAIL saturate got %h exp ff10", credit);
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         bus.src_valid_i = 2'b01;
      end
      @(negedge clk);
      bus.src_valid_i = 2'b00;
      #1;
      n_vec++;
      if (credit[7:0] !== 8'd5) begin
         n_err++; $display("FAIL same_pre got %0d exp 5", credit[7:0]);
      end
      @(negedge clk);
      bus.src_valid_i = 2'b01;
      credit_ret      = 2'b01;
      #1;
      n_vec++;
      if (bus.src_ready_o !== 2'b01) begin
         n_err++; $display("FAIL same_rdy got %b exp 01", bus.src_ready_o);
      end
      @(posedge clk); #1;
      n_vec++;
      if (credit[7:0] !== 8'd5) begin
         n_err++; $display("FAIL same_credit got %0d exp 5", credit[7:0]);
      end
      @(negedge clk);
      bus.src_valid_i = 2'b00;
      credit_ret      = 2'b00;
   endtask

   task automatic test_stall();
      do_reset();
      @(negedge clk);
      bus.src_valid_i = 2'b11;
      bus.dst_ready_i = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.dst_ready_i = 1'b0;
         bus.src_data_i  = {32'(i), 32'(i + 50)};
         #1;
         n_vec++;
         if (bus.src_ready_o !== 2'b00) begin
            n_err++; $display("FAIL stall_rdy[%0d] got %b exp 00", i, bus.src_ready_o);
         end
         @(posedge clk); #1;
         n_vec++;
         if (bus.dst_valid_o !== 1'b1 || bus.dst_data_o !== D0 || bus.dst_vc_o !== 1'b0) begin
            n_err++;
            $display("FAIL stall_hold[%0d] got v=%b d=%h vc=%0d exp 1/%h/0",
                     i, bus.dst_valid_o, bus.dst_data_o, bus.dst_vc_o, D0);
         end
      end
      n_vec++;
      if (credit !== {8'd16, 8'd15}) begin
         n_err++; $display("FAIL stall_credit got %h exp 100f", credit);
      end
      @(negedge clk);
      bus.dst_ready_i = 1'b1;
      bus.src_data_i  = {D1, D0};
      #1;
      n_vec++;
      if (bus.src_ready_o !== 2'b10) begin
         n_err++; $display("FAIL stall_release got %b exp 10", bus.src_ready_o);
      end
      @(posedge clk); #1;
      n_vec++;
      if (bus.dst_vc_o !== 1'b1 || bus.dst_data_o !== D1) begin
         n_err++; $display("FAIL stall_next got vc=%0d d=%h exp 1/%h", bus.dst_vc_o, bus.dst_data_o, D1);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.src_valid_i = 2'b11;
      end
      @(posedge clk); #1;
      n_vec++;
      if (bus.dst_valid_o !== 1'b1 || bus.dst_vc_o !== 1'b1) begin
         n_err++; $display("FAIL mid_pre got v=%b vc=%0d exp 1/1", bus.dst_valid_o, bus.dst_vc_o);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (bus.dst_valid_o !== 1'b0 || bus.src_ready_o !== 2'b00 || credit !== {8'd16, 8'd16}) begin
         n_err++;
         $display("FAIL mid_reset got v=%b rdy=%b cr=%h exp 0/00/1010",
                  bus.dst_valid_o, bus.src_ready_o, credit);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_vec++;
      if (bus.src_ready_o !== 2'b01) begin
         n_err++; $display("FAIL mid_first got %b exp 01", bus.src_ready_o);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      clear_inputs();
      test_reset();
      test_wrr();
      test_back_to_back();
      test_credit_exhaust();
      test_credit_saturate();
      test_same_cycle();
      test_stall();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
